// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM sequencing the shared RV32 datapath one
// instruction at a time (fetch, decode, execute, memory, writeback).
// Inputs: clk, rst_n (async active-low), run, opcode, func3, mem_ready,
//   alu_zero.
// Outputs: alu_op, alusrc, mem_to_reg, regwrite, mem_read, mem_write, iord,
//   ir_write, pc_write, branch, retire, trap, trap_cause.
// Optional macro PERF_CNT_EN adds cycle_cnt and instret counter outputs.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       mem_ready,
    input  logic       alu_zero,
    output logic [1:0] alu_op,
    output logic       alusrc,
    output logic       mem_to_reg,
    output logic       regwrite,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic       retire,
    output logic       trap,
    output logic [1:0] trap_cause
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
`endif
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR,
        S_MEM_RD, S_WB_LD, S_MEM_WR, S_BRANCH, S_TRAP
    } state_t;

    state_t        state_q, state_d, ret_st;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          st_q, st_d;
    logic          bne_q, bne_d;
    logic [1:0]    cause_q, cause_d;
    logic [1:0]    alu_op_q, alu_op_d;
    logic          alusrc_q, alusrc_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic          regwrite_q, regwrite_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          iord_q, iord_d;
    logic          branch_q, branch_d;
    logic          trap_q, trap_d;
    logic          wait_st, tmo_hit;

    // Next state, trap cause and the memory wait counter.
    always_comb begin
        wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);
        // A ready on the limit cycle wins over the timeout.
        tmo_hit = (MEM_TIMEOUT != 0) && wait_st && !mem_ready &&
                  (int'(tmo_q) + 1 >= MEM_TIMEOUT);
        ret_st  = run ? S_FETCH : S_IDLE;
        state_d = state_q;
        cause_d = cause_q;
        st_d    = st_q;
        bne_d   = bne_q;
        tmo_d   = '0;
        unique case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    opcode == OP_R: state_d = S_EXEC_R;
                    (opcode == OP_LD) || (opcode == OP_ST): begin
                        state_d = S_ADDR;
                        st_d    = (opcode == OP_ST);
                    end
                    (opcode == OP_BR) && (func3[2:1] == 2'b00): begin
                        state_d = S_BRANCH;
                        bne_d   = func3[0];
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_ADDR:   state_d = st_q ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
            S_MEM_WR: if (mem_ready) state_d = ret_st;
            S_WB_R, S_WB_LD, S_BRANCH: state_d = ret_st;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_IDLE;
        endcase
        if (tmo_hit) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
        end else if (wait_st && !mem_ready && (MEM_TIMEOUT != 0)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Moore outputs decoded from the next state so they leave a flop.
    always_comb begin
        alu_op_d     = 2'b00;
        alusrc_d     = 1'b0;
        mem_to_reg_d = 1'b0;
        regwrite_d   = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        iord_d       = 1'b0;
        branch_d     = 1'b0;
        trap_d       = 1'b0;
        unique case (state_d)
            S_FETCH:  mem_read_d = 1'b1;
            S_EXEC_R: alu_op_d = 2'b10;
            S_WB_R: begin
                alu_op_d   = 2'b10;
                regwrite_d = 1'b1;
            end
            S_ADDR:   alusrc_d = 1'b1;
            S_MEM_RD: begin
                mem_read_d = 1'b1;
                iord_d     = 1'b1;
                alusrc_d   = 1'b1;
            end
            S_WB_LD: begin
                regwrite_d   = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_MEM_WR: begin
                mem_write_d = 1'b1;
                iord_d      = 1'b1;
                alusrc_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_op_d = 2'b01;
                branch_d = 1'b1;
            end
            S_TRAP:   trap_d = 1'b1;
            default:  ;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instret_d   = instret_q;
        if ((state_q != S_IDLE) && (state_q != S_TRAP))
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (retire)
            instret_d = instret_q + 1'b1;
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instret   = instret_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            tmo_q        <= '0;
            st_q         <= 1'b0;
            bne_q        <= 1'b0;
            cause_q      <= 2'b00;
            alu_op_q     <= 2'b00;
            alusrc_q     <= 1'b0;
            mem_to_reg_q <= 1'b0;
            regwrite_q   <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            iord_q       <= 1'b0;
            branch_q     <= 1'b0;
            trap_q       <= 1'b0;
`ifdef PERF_CNT_EN
            cycle_cnt_q  <= '0;
            instret_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            st_q         <= st_d;
            bne_q        <= bne_d;
            cause_q      <= cause_d;
            alu_op_q     <= alu_op_d;
            alusrc_q     <= alusrc_d;
            mem_to_reg_q <= mem_to_reg_d;
            regwrite_q   <= regwrite_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            iord_q       <= iord_d;
            branch_q     <= branch_d;
            trap_q       <= trap_d;
`ifdef PERF_CNT_EN
            cycle_cnt_q  <= cycle_cnt_d;
            instret_q    <= instret_d;
`endif
        end
    end

    assign alu_op     = alu_op_q;
    assign alusrc     = alusrc_q;
    assign mem_to_reg = mem_to_reg_q;
    assign regwrite   = regwrite_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign iord       = iord_q;
    assign branch     = branch_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

    // Same-cycle qualified strobes.
    assign ir_write = (state_q == S_FETCH) && mem_ready;
    assign pc_write = ir_write ||
                      ((state_q == S_BRANCH) && (alu_zero ^ bne_q));
    assign retire   = (state_q == S_WB_R) || (state_q == S_WB_LD) ||
                      (state_q == S_BRANCH) ||
                      ((state_q == S_MEM_WR) && mem_ready);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed bench; an instruction-level trace model
// expands each instruction into its expected per-cycle outputs.
module tb_multicycle_ctrl;
    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic       mem_ready = 1'b0;
    logic       alu_zero = 1'b0;
    logic [1:0] alu_op;
    logic       alusrc, mem_to_reg, regwrite, mem_read, mem_write, iord;
    logic       ir_write, pc_write, branch, retire, trap;
    logic [1:0] trap_cause;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_cnt, instret;
`endif

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
        .func3(func3), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .alu_op(alu_op), .alusrc(alusrc), .mem_to_reg(mem_to_reg),
        .regwrite(regwrite), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .branch(branch), .retire(retire), .trap(trap),
        .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret(instret)
`endif
    );

    typedef struct packed {
        logic [1:0] alu_op;
        logic alusrc, mem_to_reg, regwrite, mem_read, mem_write, iord;
        logic ir_write, pc_write, branch, retire, trap;
        logic [1:0] cause;
    } outs_t;

    typedef struct packed {
        logic       run;
        logic [6:0] opc;
        logic [2:0] f3;
        logic       mr;
        logic       az;
        outs_t      o;
    } cyc_t;

    cyc_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         last_lat;
    logic [6:0] cur_opc;
    logic [2:0] cur_f3;
    logic       cur_az;
    logic       mid_run;
    string      scen;

    function automatic outs_t dut_outs();
        return {alu_op, alusrc, mem_to_reg, regwrite, mem_read, mem_write,
                iord, ir_write, pc_write, branch, retire, trap, trap_cause};
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic cyc_t blank();
        cyc_t c;
        c     = '0;
        c.run = mid_run;
        c.opc = cur_opc;
        c.f3  = cur_f3;
        c.az  = cur_az;
        return c;
    endfunction

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f,
                             input logic az);
        cur_opc = op;
        cur_f3  = f;
        cur_az  = az;
    endtask

    task automatic push_idle(input logic r);
        cyc_t c;
        c     = blank();
        c.run = r;
        q.push_back(c);
    endtask

    task automatic push_fetch(input int w);
        cyc_t c;
        for (int i = 0; i < w; i++) begin
            c            = blank();
            c.o.mem_read = 1'b1;
            q.push_back(c);
        end
        c            = blank();
        c.mr         = 1'b1;
        c.o.mem_read = 1'b1;
        c.o.ir_write = 1'b1;
        c.o.pc_write = 1'b1;
        q.push_back(c);
    endtask

    task automatic push_decode();
        q.push_back(blank());
    endtask

    task automatic push_addr();
        cyc_t c;
        c          = blank();
        c.o.alusrc = 1'b1;
        q.push_back(c);
    endtask

    task automatic push_trap(input int n, input logic [1:0] cause);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c         = blank();
            c.run     = 1'b1;
            c.mr      = 1'b1;
            c.o.trap  = 1'b1;
            c.o.cause = cause;
            q.push_back(c);
        end
    endtask

    task automatic instr_r(input int fw, input logic ra);
        cyc_t c;
        set_instr(7'b0110011, 3'b000, 1'b0);
        push_fetch(fw);
        push_decode();
        c          = blank();
        c.o.alu_op = 2'b10;
        q.push_back(c);
        c            = blank();
        c.run        = ra;
        c.o.alu_op   = 2'b10;
        c.o.regwrite = 1'b1;
        c.o.retire   = 1'b1;
        q.push_back(c);
    endtask

    task automatic instr_ld(input int fw, input int mw, input logic ra);
        cyc_t c;
        set_instr(7'b0000011, 3'b010, 1'b0);
        push_fetch(fw);
        push_decode();
        push_addr();
        for (int i = 0; i <= mw; i++) begin
            c            = blank();
            c.mr         = (i == mw);
            c.o.mem_read = 1'b1;
            c.o.iord     = 1'b1;
            c.o.alusrc   = 1'b1;
            q.push_back(c);
        end
        c              = blank();
        c.run          = ra;
        c.o.regwrite   = 1'b1;
        c.o.mem_to_reg = 1'b1;
        c.o.retire     = 1'b1;
        q.push_back(c);
    endtask

    task automatic instr_st(input int fw, input int mw, input logic ra);
        cyc_t c;
        set_instr(7'b0100011, 3'b010, 1'b0);
        push_fetch(fw);
        push_decode();
        push_addr();
        for (int i = 0; i <= mw; i++) begin
            c             = blank();
            c.mr          = (i == mw);
            c.run         = (i == mw) ? ra : mid_run;
            c.o.mem_write = 1'b1;
            c.o.iord      = 1'b1;
            c.o.alusrc    = 1'b1;
            c.o.retire    = (i == mw);
            q.push_back(c);
        end
    endtask

    task automatic instr_br(input logic [2:0] f, input logic az,
                            input logic ra);
        cyc_t c;
        set_instr(7'b1100011, f, az);
        push_fetch(0);
        push_decode();
        c            = blank();
        c.run        = ra;
        c.o.alu_op   = 2'b01;
        c.o.branch   = 1'b1;
        c.o.retire   = 1'b1;
        c.o.pc_write = (f == 3'b000) ? az : !az;
        q.push_back(c);
    endtask

    task automatic instr_bad(input logic [6:0] op, input logic [2:0] f,
                             input int n);
        set_instr(op, f, 1'b0);
        push_fetch(0);
        push_decode();
        push_trap(n, 2'b01);
    endtask

    task automatic store_timeout(input int n);
        cyc_t c;
        set_instr(7'b0100011, 3'b010, 1'b0);
        push_fetch(0);
        push_decode();
        push_addr();
        for (int i = 0; i < TMO; i++) begin
            c             = blank();
            c.o.mem_write = 1'b1;
            c.o.iord      = 1'b1;
            c.o.alusrc    = 1'b1;
            q.push_back(c);
        end
        push_trap(n, 2'b10);
    endtask

    task automatic fetch_timeout(input int n);
        cyc_t c;
        set_instr(7'b0110011, 3'b000, 1'b0);
        for (int i = 0; i < TMO; i++) begin
            c            = blank();
            c.o.mem_read = 1'b1;
            q.push_back(c);
        end
        push_trap(n, 2'b10);
    endtask

    // Drive each modelled cycle, compare outputs, measure latency.
    task automatic play();
        cyc_t  c;
        outs_t got;
        int    idx = 0;
        int    start = 0;
        bit    busy = 0;
        while (q.size() > 0) begin
            c         = q.pop_front();
            run       = c.run;
            opcode    = c.opc;
            func3     = c.f3;
            mem_ready = c.mr;
            alu_zero  = c.az;
            #1;
            got = dut_outs();
            checks++;
            if (got !== c.o) begin
                errors++;
                $display("FAIL %s cyc %0d: got %b expected %b",
                         scen, idx, got, c.o);
            end
            if (!busy && mem_read && !iord) begin
                busy  = 1;
                start = idx;
            end
            if (retire) begin
                last_lat = idx - start + 1;
                busy     = 0;
            end
            idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b1;
        run       = 1'b0;
        mem_ready = 1'b0;
        alu_zero  = 1'b0;
        opcode    = '0;
        func3     = '0;
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_outs", 32'(dut_outs()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        last_lat = -1;
        mid_run  = 1'b1;
        set_instr(7'd0, 3'd0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        scen = "rtype";
        do_reset();
        mid_run = 1'b0;
        push_idle(1'b1);
        instr_r(0, 1'b0);
        push_idle(1'b0);
        push_idle(1'b0);
        play();
        check("rtype_lat", 32'(last_lat), 32'd4);

        scen = "load";
        do_reset();
        push_idle(1'b1);
        instr_ld(0, 3, 1'b0);
        push_idle(1'b0);
        play();
        check("load_lat", 32'(last_lat), 32'd8);

        scen = "store";
        do_reset();
        push_idle(1'b1);
        instr_st(0, 0, 1'b0);
        push_idle(1'b0);
        play();
        check("store_lat", 32'(last_lat), 32'd4);

        scen = "st_beq_bne";
        do_reset();
        push_idle(1'b1);
        instr_st(0, 0, 1'b1);
        instr_br(3'b000, 1'b1, 1'b1);
        instr_br(3'b001, 1'b1, 1'b0);
        push_idle(1'b0);
        play();
        check("bne_lat", 32'(last_lat), 32'd3);

        scen = "r_wait_br";
        do_reset();
        push_idle(1'b1);
        instr_r(3, 1'b1);
        instr_br(3'b000, 1'b0, 1'b1);
        instr_br(3'b001, 1'b0, 1'b0);
        push_idle(1'b0);
        play();
        check("beq_lat", 32'(last_lat), 32'd3);

        scen = "illegal";
        do_reset();
        push_idle(1'b1);
        instr_bad(7'b1111111, 3'b000, 4);
        play();
        check("ill_trap", 32'(trap), 32'd1);
        check("ill_cause", 32'(trap_cause), 32'd1);
        check("ill_noread", 32'(mem_read), 32'd0);

        scen = "bad_branch";
        do_reset();
        push_idle(1'b1);
        instr_bad(7'b1100011, 3'b010, 3);
        play();
        check("badbr_cause", 32'(trap_cause), 32'd1);

        scen = "st_timeout";
        do_reset();
        push_idle(1'b1);
        store_timeout(3);
        play();
        check("sttmo_cause", 32'(trap_cause), 32'd2);
        check("sttmo_nowr", 32'(mem_write), 32'd0);

        scen = "st_ready_limit";
        do_reset();
        push_idle(1'b1);
        instr_st(0, 3, 1'b0);
        push_idle(1'b0);
        play();
        check("stlim_lat", 32'(last_lat), 32'd7);
        check("stlim_notrap", 32'(trap), 32'd0);

        scen = "fetch_timeout";
        do_reset();
        push_idle(1'b1);
        fetch_timeout(2);
        play();
        check("ftmo_cause", 32'(trap_cause), 32'd2);

        scen = "async_rst";
        do_reset();
        set_instr(7'b0100011, 3'b010, 1'b0);
        push_idle(1'b1);
        push_fetch(0);
        push_decode();
        push_addr();
        instr_st_wait_entry();
        play();
        check("pre_rst_wr", 32'(mem_write), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", 32'(dut_outs()), 32'd0);

`ifdef PERF_CNT_EN
        scen = "perf";
        do_reset();
        check("perf_rst_ir", instret, 32'd0);
        check("perf_rst_cy", cycle_cnt, 32'd0);
        push_idle(1'b1);
        instr_r(0, 1'b1);
        instr_r(0, 1'b1);
        instr_r(0, 1'b0);
        push_idle(1'b0);
        play();
        check("perf_instret", instret, 32'd3);
        check("perf_cycles", cycle_cnt, 32'd12);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic instr_st_wait_entry();
        cyc_t c;
        c             = blank();
        c.o.mem_write = 1'b1;
        c.o.iord      = 1'b1;
        c.o.alusrc    = 1'b1;
        q.push_back(c);
    endtask
endmodule
